// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the CPU/loader memory port arbiter.
// Holds the FSM state encoding and the port identifiers used by the arbiter and its response router.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    LDR  = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_rsp_router.sv
// One-cycle read-response pipeline: remembers which port issued a read and
// steers the memory's read data to that port, holding each port's last data.
module mem_rsp_router
  import mem_port_arbiter_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue_valid,
  input  logic          issue_owner,
  input  logic [DW-1:0] m_rdata,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata
);

  logic          pipe_valid;
  logic          pipe_owner;
  logic [DW-1:0] c_hold;
  logic [DW-1:0] l_hold;

  // An asynchronous reset drops any read still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= 1'b0;
      pipe_owner <= PORT_CPU;
    end else begin
      pipe_valid <= issue_valid;
      pipe_owner <= issue_owner;
    end
  end

  assign c_rvalid = pipe_valid && (pipe_owner == PORT_CPU);
  assign l_rvalid = pipe_valid && (pipe_owner == PORT_LDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_hold <= '0;
      l_hold <= '0;
    end else begin
      if (c_rvalid) c_hold <= m_rdata;
      if (l_rvalid) l_hold <= m_rdata;
    end
  end

  // Fresh data passes straight through in the response cycle.
  assign c_rdata = c_rvalid ? m_rdata : c_hold;
  assign l_rdata = l_rvalid ? m_rdata : l_hold;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between a CPU
// and a loader, with a loader burst limit so a waiting CPU cannot be starved.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          cpu_stall
);

  localparam int            BW        = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  arb_state_t    state;
  arb_state_t    state_next;
  logic          last_owner;
  logic [BW-1:0] burst_cnt;
  logic          cpu_first;

  // State holds last cycle's owner; when idle, last_owner keeps the round-robin memory.
  always_comb begin
    c_gnt      = 1'b0;
    l_gnt      = 1'b0;
    state_next = IDLE;
    cpu_first  = (state == LDR) ||
                 ((state == IDLE) && (last_owner == PORT_LDR)) ||
                 (burst_cnt == BURST_MAX);
    if (!reset) begin
      if (c_req && (!l_req || cpu_first)) c_gnt = 1'b1;
      else if (l_req)                     l_gnt = 1'b1;
    end
    if (c_gnt)      state_next = CPU;
    else if (l_gnt) state_next = LDR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= PORT_LDR;
      burst_cnt  <= '0;
    end else begin
      state <= state_next;
      if (c_gnt)      last_owner <= PORT_CPU;
      else if (l_gnt) last_owner <= PORT_LDR;
      if (!l_gnt)                      burst_cnt <= '0;
      else if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // The memory bus is idle-zero unless a port owns it this cycle.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (c_gnt) begin
      m_en    = 1'b1;
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (l_gnt) begin
      m_en    = 1'b1;
      m_we    = l_we;
      m_addr  = l_addr;
      m_wdata = l_wdata;
    end
  end

  assign cpu_stall = c_req && !c_gnt && !reset;

  logic issue_valid;
  logic issue_owner;

  assign issue_valid = (c_gnt && !c_we) || (l_gnt && !l_we);
  assign issue_owner = l_gnt ? PORT_LDR : PORT_CPU;

  mem_rsp_router #(
    .DW(DW)
  ) u_rsp_router (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_owner(issue_owner),
    .m_rdata    (m_rdata),
    .c_rvalid   (c_rvalid),
    .c_rdata    (c_rdata),
    .l_rvalid   (l_rvalid),
    .l_rdata    (l_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration and read-response rules.
module tb_mem_port_arbiter;

  localparam int AW        = 16;
  localparam int DW        = 32;
  localparam int MAX_BURST = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [AW-1:0] c_addr = '0, l_addr = '0;
  logic [DW-1:0] c_wdata = '0, l_wdata = '0;
  logic          c_gnt, c_rvalid, l_gnt, l_rvalid;
  logic [DW-1:0] c_rdata, l_rdata;
  logic          m_en, m_we, cpu_stall;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata = '0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .cpu_stall(cpu_stall)
  );

  // Unwritten locations read back a fixed pattern; 0x0010 holds 0xDEADBEEF.
  function automatic logic [DW-1:0] bg_word(input logic [AW-1:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {a ^ 16'h5A5A, a};
  endfunction

  logic [DW-1:0] mem [logic [AW-1:0]];

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] = m_wdata;
      else      m_rdata <= mem.exists(m_addr) ? mem[m_addr] : bg_word(m_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    c_req = 1'b1; c_addr = 16'h0044;
    l_req = 1'b1; l_addr = 16'h0055; l_wdata = 32'hFFFF0000;
    @(negedge clk);
    checks++;
    if ({c_gnt, l_gnt} !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_gnt got=%b exp=00", {c_gnt, l_gnt});
    end
    checks++;
    if ({m_en, m_we, m_addr, m_wdata} !== '0) begin
      failures++; $display("[TB] FAIL reset_mbus got en=%b we=%b addr=%h wdata=%h exp=0", m_en, m_we, m_addr, m_wdata);
    end
    checks++;
    if ({c_rvalid, l_rvalid} !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_rvalid got=%b exp=00", {c_rvalid, l_rvalid});
    end
    checks++;
    if ({c_rdata, l_rdata} !== '0) begin
      failures++; $display("[TB] FAIL reset_rdata got c=%h l=%h exp=0", c_rdata, l_rdata);
    end
    checks++;
    if (cpu_stall !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_stall got=%b exp=0", cpu_stall);
    end
    tick();
    idle_inputs();
    reset = 1'b0;
  endtask

  task automatic test_cpu_read();
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if ({c_gnt, l_gnt, cpu_stall} !== 3'b100) begin
      failures++; $display("[TB] FAIL cpu_read_gnt got gnt/lgnt/stall=%b exp=100", {c_gnt, l_gnt, cpu_stall});
    end
    checks++;
    if ({m_en, m_we, m_addr} !== {1'b1, 1'b0, 16'h0010}) begin
      failures++; $display("[TB] FAIL cpu_read_mbus got en=%b we=%b addr=%h exp en=1 we=0 addr=0010", m_en, m_we, m_addr);
    end
    tick();
    c_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({c_rvalid, l_rvalid, c_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      failures++; $display("[TB] FAIL cpu_read_rsp got crv=%b lrv=%b crd=%h exp 1 0 deadbeef", c_rvalid, l_rvalid, c_rdata);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({c_rvalid, c_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      failures++; $display("[TB] FAIL cpu_read_hold got crv=%b crd=%h exp 0 deadbeef", c_rvalid, c_rdata);
    end
    tick();
  endtask

  task automatic test_alternate();
    bit exp_c;
    bit prev_c;
    do_reset();
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0200;
    l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0201;
    prev_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_c = (i % 2 == 0);
      @(negedge clk);
      checks++;
      if ({c_gnt, l_gnt} !== {exp_c, !exp_c}) begin
        failures++; $display("[TB] FAIL alternate_gnt i=%0d got=%b exp=%b", i, {c_gnt, l_gnt}, {exp_c, !exp_c});
      end
      if (i > 0) begin
        checks++;
        if ({c_rvalid, l_rvalid} !== {prev_c, !prev_c}) begin
          failures++; $display("[TB] FAIL alternate_rvalid i=%0d got=%b exp=%b", i, {c_rvalid, l_rvalid}, {prev_c, !prev_c});
        end
      end
      prev_c = exp_c;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_burst();
    int ldr_grants = 0;
    int cpu_grants = 0;
    int run        = 0;
    int max_run    = 0;
    bit first_c    = 1'b0;
    do_reset();
    l_req = 1'b1; l_we = 1'b1; l_addr = 16'h0300; l_wdata = 32'hA0A0A0A0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (l_gnt) ldr_grants++;
      tick();
    end
    checks++;
    if (ldr_grants != 20) begin
      failures++; $display("[TB] FAIL burst_ldr_alone got=%0d exp=20", ldr_grants);
    end
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0301; c_wdata = 32'h0B0B0B0B;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) first_c = c_gnt;
      if (c_gnt) cpu_grants++;
      run = cpu_stall ? run + 1 : 0;
      if (run > max_run) max_run = run;
      tick();
    end
    checks++;
    if (first_c !== 1'b1) begin
      failures++; $display("[TB] FAIL burst_cpu_first got=%b exp=1", first_c);
    end
    checks++;
    if (max_run > 1) begin
      failures++; $display("[TB] FAIL burst_stall_run got=%0d exp<=1", max_run);
    end
    checks++;
    if (cpu_grants != 4) begin
      failures++; $display("[TB] FAIL burst_cpu_share got=%0d exp=4", cpu_grants);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_write_read();
    l_req = 1'b1; l_we = 1'b1; l_addr = 16'h0100; l_wdata = 32'h12345678;
    @(negedge clk);
    checks++;
    if ({l_gnt, m_en, m_we, m_addr, m_wdata} !== {3'b111, 16'h0100, 32'h12345678}) begin
      failures++; $display("[TB] FAIL wr_ldr_write got gnt=%b en=%b we=%b addr=%h wdata=%h exp 1 1 1 0100 12345678", l_gnt, m_en, m_we, m_addr, m_wdata);
    end
    tick();
    idle_inputs();
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0100;
    @(negedge clk);
    checks++;
    if ({c_gnt, l_rvalid} !== 2'b10) begin
      failures++; $display("[TB] FAIL wr_cpu_gnt got gnt/lrv=%b exp=10", {c_gnt, l_rvalid});
    end
    tick();
    c_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({c_rvalid, l_rvalid, c_rdata} !== {2'b10, 32'h12345678}) begin
      failures++; $display("[TB] FAIL wr_cpu_rsp got crv=%b lrv=%b crd=%h exp 1 0 12345678", c_rvalid, l_rvalid, c_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0020;
    @(negedge clk);
    checks++;
    if (l_gnt !== 1'b1) begin
      failures++; $display("[TB] FAIL rstmid_ldr_gnt got=%b exp=1", l_gnt);
    end
    tick();
    reset = 1'b1;
    idle_inputs();
    c_req = 1'b1; c_we = 1'b0; c_addr = 16'h0040;
    @(negedge clk);
    checks++;
    if ({c_rvalid, l_rvalid, c_rdata, l_rdata} !== '0) begin
      failures++; $display("[TB] FAIL rstmid_rsp got crv=%b lrv=%b crd=%h lrd=%h exp 0", c_rvalid, l_rvalid, c_rdata, l_rdata);
    end
    checks++;
    if ({c_gnt, l_gnt, cpu_stall, m_en, m_we, m_addr, m_wdata} !== '0) begin
      failures++; $display("[TB] FAIL rstmid_outputs got gnt=%b lgnt=%b stall=%b en=%b addr=%h exp 0", c_gnt, l_gnt, cpu_stall, m_en, m_addr);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({c_gnt, m_en, m_addr} !== {2'b11, 16'h0040}) begin
      failures++; $display("[TB] FAIL rstmid_regrant got gnt=%b en=%b addr=%h exp 1 1 0040", c_gnt, m_en, m_addr);
    end
    tick();
    c_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({c_rvalid, l_rvalid} !== 2'b10) begin
      failures++; $display("[TB] FAIL rstmid_after got crv/lrv=%b exp=10", {c_rvalid, l_rvalid});
    end
    tick();
  endtask

  task automatic test_abandon();
    int bad = 0;
    c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0030; c_wdata = 32'h00C0FFEE;
    @(negedge clk);
    checks++;
    if (c_gnt !== 1'b1) begin
      failures++; $display("[TB] FAIL abandon_setup got=%b exp=1", c_gnt);
    end
    tick();
    c_we = 1'b0; c_addr = 16'h0044;
    l_req = 1'b1; l_we = 1'b0; l_addr = 16'h0050;
    @(negedge clk);
    checks++;
    if ({c_gnt, l_gnt, cpu_stall} !== 3'b011) begin
      failures++; $display("[TB] FAIL abandon_ldr_wins got gnt/lgnt/stall=%b exp=011", {c_gnt, l_gnt, cpu_stall});
    end
    tick();
    c_req = 1'b0;
    l_addr = 16'h0051;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ((m_en && m_addr == 16'h0044) || c_rvalid || c_gnt) bad++;
      tick();
      l_req = 1'b0;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("[TB] FAIL abandon_no_access got=%0d bad cycles exp=0", bad);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    bit c_act = 1'b0, l_act = 1'b0, c_done = 1'b0, l_done = 1'b0;
    bit mdl_last = 1'b1;
    int mdl_burst = 0;
    bit pend_v = 1'b0, pend_p = 1'b0;
    bit ec, el, erc, erl;
    logic [DW-1:0] pend_d = '0, exp_crd = '0, exp_lrd = '0;
    logic [AW+DW+1:0] exp_bus, got_bus;
    logic [AW-1:0] a;
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (c_act && (c_done || $urandom_range(0, 99) < 4)) c_act = 1'b0;
      if (!c_act && $urandom_range(0, 99) < 55) begin
        c_act = 1'b1; c_we = 1'($urandom_range(0, 1));
        c_addr = 16'h0200 | 16'($urandom_range(0, 15)); c_wdata = $urandom;
      end
      c_req = c_act;
      if (l_act && (l_done || $urandom_range(0, 99) < 4)) l_act = 1'b0;
      if (!l_act && $urandom_range(0, 99) < 70) begin
        l_act = 1'b1; l_we = 1'($urandom_range(0, 1));
        l_addr = 16'h0200 | 16'($urandom_range(0, 15)); l_wdata = $urandom;
      end
      l_req = l_act;
      @(negedge clk);
      ec = c_req && (!l_req || mdl_last || mdl_burst >= MAX_BURST);
      el = l_req && !ec;
      exp_bus = ec ? {1'b1, c_we, c_addr, c_wdata} : el ? {1'b1, l_we, l_addr, l_wdata} : '0;
      got_bus = {m_en, m_we, m_addr, m_wdata};
      erc = pend_v && !pend_p;
      erl = pend_v && pend_p;
      if (erc) exp_crd = pend_d;
      if (erl) exp_lrd = pend_d;
      checks++;
      if ({c_gnt, l_gnt, cpu_stall} !== {ec, el, c_req && !ec}) begin
        failures++; $display("[TB] FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, {c_gnt, l_gnt, cpu_stall}, {ec, el, c_req && !ec});
      end
      checks++;
      if (got_bus !== exp_bus) begin
        failures++; $display("[TB] FAIL rand_mbus cyc=%0d got=%h exp=%h", cyc, got_bus, exp_bus);
      end
      checks++;
      if ({c_rvalid, c_rdata} !== {erc, exp_crd}) begin
        failures++; $display("[TB] FAIL rand_cpu_rsp cyc=%0d got rv=%b d=%h exp rv=%b d=%h", cyc, c_rvalid, c_rdata, erc, exp_crd);
      end
      checks++;
      if ({l_rvalid, l_rdata} !== {erl, exp_lrd}) begin
        failures++; $display("[TB] FAIL rand_ldr_rsp cyc=%0d got rv=%b d=%h exp rv=%b d=%h", cyc, l_rvalid, l_rdata, erl, exp_lrd);
      end
      pend_v = 1'b0;
      if (ec || el) begin
        a = ec ? c_addr : l_addr;
        if ((ec && c_we) || (el && l_we)) ref_mem[a] = ec ? c_wdata : l_wdata;
        else begin
          pend_v = 1'b1;
          pend_p = el;
          pend_d = ref_mem.exists(a) ? ref_mem[a] : bg_word(a);
        end
        mdl_last = el;
      end
      mdl_burst = el ? ((mdl_burst < MAX_BURST) ? mdl_burst + 1 : MAX_BURST) : 0;
      c_done = ec;
      l_done = el;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_alternate();
    test_burst();
    test_write_read();
    test_reset_mid();
    test_abandon();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
